// File: rtl/izneuron_pool.sv
// izneuron_pool: time-multiplexed Izhikevich neuron population.
// One shared fixed-point datapath advances N_NEURONS neurons by one Euler
// step (dt = 1 ms) per sweep. The u and v states live in two synchronous RAMs.
// A sweep starts on a one-cycle `step` strobe while the block is idle.
//
// Ports:
//   clk, reset      single clock, synchronous active-high reset
//   step            start-of-sweep strobe (ignored unless idle)
//   I_in            Q.10 input current for neuron `cur_index`, sampled in RD
//   mon_index       neuron whose updated v is reported on `v_out`
//   cur_index       neuron currently being read
//   busy            high while the RAMs initialise or a sweep runs
//   done            one-cycle pulse in the final state of a sweep
//   spike_valid     spike event strobe; spike_index gives the neuron
//   v_out           most recent new v of the monitored neuron
//   population      spike flags of the last completed sweep
//   spike_count     number of spikes in the last completed sweep
module izneuron_pool #(
  parameter int N_NEURONS = 128,
  parameter int IDX_W     = $clog2(N_NEURONS),
  parameter int A         = 82,
  parameter int B         = 205,
  parameter int C         = -66560,
  parameter int D         = 2048,
  parameter int V_INIT    = -66560,
  parameter int U_INIT    = -13312,
  parameter int V_MAX     = 102400,
  parameter int V_PEAK    = 30720
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    step,
  input  logic signed [31:0]      I_in,
  input  logic [IDX_W-1:0]        mon_index,
  output logic [IDX_W-1:0]        cur_index,
  output logic                    busy,
  output logic                    done,
  output logic                    spike_valid,
  output logic [IDX_W-1:0]        spike_index,
  output logic signed [31:0]      v_out,
  output logic [N_NEURONS-1:0]    population,
  output logic [IDX_W:0]          spike_count
);

  typedef enum logic [2:0] {
    INIT = 3'd0,
    IDLE = 3'd1,
    RD   = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(N_NEURONS - 1);
  localparam logic signed [63:0] A_64      = 64'(A);
  localparam logic signed [63:0] B_64      = 64'(B);
  localparam logic signed [31:0] C_32      = 32'(C);
  localparam logic signed [31:0] D_32      = 32'(D);
  localparam logic signed [31:0] V_INIT_32 = 32'(V_INIT);
  localparam logic signed [31:0] U_INIT_32 = 32'(U_INIT);
  localparam logic signed [31:0] V_MAX_32  = 32'(V_MAX);
  localparam logic signed [31:0] V_PEAK_32 = 32'(V_PEAK);

  state_t                  state_r, state_s;
  logic [IDX_W-1:0]        idx_r;
  logic signed [31:0]      v_mem [N_NEURONS];
  logic signed [31:0]      u_mem [N_NEURONS];
  logic signed [31:0]      v_rd_r, u_rd_r, i_r;
  logic [N_NEURONS-1:0]    pop_acc_r;
  logic [IDX_W:0]          cnt_acc_r;

  logic                    last_s, wr_en_s, fired_s;
  logic signed [63:0]      v_64_s, vv_64_s, diff_64_s;
  logic signed [63:0]      vv_p_s, q_p_s, bv_p_s, du_p_s;
  logic signed [31:0]      vv_s, q_s, dv_s, bv_s, diff_s, du_s, v_sum_s;
  logic signed [31:0]      v_new_s, u_new_s, wr_v_s, wr_u_s;

  assign last_s    = (idx_r == LAST_IDX);
  assign cur_index = idx_r;

  // Next-state logic of the sweep controller.
  always_comb begin
    state_s = state_r;
    case (state_r)
      INIT: if (last_s) state_s = IDLE; else state_s = INIT;
      IDLE: if (step)   state_s = RD;   else state_s = IDLE;
      RD:   state_s = WR;
      WR:   if (last_s) state_s = DONE; else state_s = RD;
      DONE: state_s = IDLE;
      default: state_s = INIT;
    endcase
  end

  // State register and neuron index; the index only wraps through DONE/IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= INIT;
      idx_r   <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_s;
      case (state_r)
        INIT:    idx_r <= last_s ? {IDX_W{1'b0}} : idx_r + 1'b1;
        WR:      idx_r <= last_s ? idx_r : idx_r + 1'b1;
        RD:      idx_r <= idx_r;
        default: idx_r <= {IDX_W{1'b0}};
      endcase
    end
  end

  // Euler update of the neuron read in RD; products are 64-bit, sums wrap at 32.
  always_comb begin
    v_64_s    = 64'(v_rd_r);
    vv_p_s    = v_64_s * v_64_s;
    vv_s      = 32'(vv_p_s >>> 10);
    vv_64_s   = 64'(vv_s);
    q_p_s     = vv_64_s * 64'sd41;
    q_s       = 32'(q_p_s >>> 10);
    dv_s      = q_s + 32'sd5 * v_rd_r + 32'sd143360 - u_rd_r + i_r;
    bv_p_s    = v_64_s * B_64;
    bv_s      = 32'(bv_p_s >>> 10);
    diff_s    = bv_s - u_rd_r;
    diff_64_s = 64'(diff_s);
    du_p_s    = diff_64_s * A_64;
    du_s      = 32'(du_p_s >>> 12);
    v_sum_s   = v_rd_r + dv_s;
    // The spike test uses the stored v, before this step's update.
    fired_s   = (v_rd_r > V_PEAK_32);
    if (fired_s) begin
      v_new_s = C_32;
      u_new_s = u_rd_r + D_32;
    end else begin
      u_new_s = u_rd_r + du_s;
      if (v_sum_s > V_MAX_32) v_new_s = V_MAX_32;
      else                    v_new_s = v_sum_s;
    end
  end

  // RAM write data: initial values during INIT, the update during WR.
  always_comb begin
    wr_en_s = (state_r == INIT) || (state_r == WR);
    if (state_r == INIT) begin
      wr_v_s = V_INIT_32;
      wr_u_s = U_INIT_32;
    end else begin
      wr_v_s = v_new_s;
      wr_u_s = u_new_s;
    end
  end

  // State RAMs: one write port and a registered read at the current index.
  always_ff @(posedge clk) begin
    if (wr_en_s && !reset) begin
      v_mem[idx_r] <= wr_v_s;
      u_mem[idx_r] <= wr_u_s;
    end
    v_rd_r <= v_mem[idx_r];
    u_rd_r <= u_mem[idx_r];
  end

  // Input current is captured in RD, alongside the RAM read of the same neuron.
  always_ff @(posedge clk) begin
    if (reset)              i_r <= 32'sd0;
    else if (state_r == RD) i_r <= I_in;
    else                    i_r <= i_r;
  end

  // Status outputs, spike events, monitor tap and sweep accumulators.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= 1'b1;
      done        <= 1'b0;
      spike_valid <= 1'b0;
      spike_index <= {IDX_W{1'b0}};
      v_out       <= V_INIT_32;
      population  <= {N_NEURONS{1'b0}};
      spike_count <= {(IDX_W+1){1'b0}};
      pop_acc_r   <= {N_NEURONS{1'b0}};
      cnt_acc_r   <= {(IDX_W+1){1'b0}};
    end else begin
      busy        <= (state_s != IDLE);
      done        <= (state_s == DONE);
      spike_valid <= (state_r == WR) && fired_s;
      if ((state_r == IDLE) && step) begin
        pop_acc_r <= {N_NEURONS{1'b0}};
        cnt_acc_r <= {(IDX_W+1){1'b0}};
      end else if ((state_r == WR) && fired_s) begin
        pop_acc_r[idx_r] <= 1'b1;
        cnt_acc_r        <= cnt_acc_r + 1'b1;
      end
      if ((state_r == WR) && fired_s) spike_index <= idx_r;
      if ((state_r == WR) && (idx_r == mon_index)) v_out <= v_new_s;
      if (state_r == DONE) begin
        population  <= pop_acc_r;
        spike_count <= cnt_acc_r;
      end
    end
  end

endmodule

// File: tb/tb_izneuron_pool.sv
// Bench for izneuron_pool: a behavioural model predicts each sweep, pushes
// expected spike events and sweep summaries into queues, and a monitor
// process pops and compares whenever the DUT strobes spike_valid or done.
module tb_izneuron_pool;
  localparam int N      = 128;
  localparam int W      = 7;
  localparam int A      = 82;
  localparam int B      = 205;
  localparam int C      = -66560;
  localparam int D      = 2048;
  localparam int V_INIT = -66560;
  localparam int U_INIT = -13312;
  localparam int V_MAX  = 102400;
  localparam int V_PEAK = 30720;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset = 1'b1, step = 1'b0;
  logic signed [31:0]  I_in;
  logic [W-1:0]        mon_index = '0, cur_index, spike_index;
  logic                busy, done, spike_valid;
  logic signed [31:0]  v_out;
  logic [N-1:0]        population;
  logic [W:0]          spike_count;

  logic                step4 = 1'b0;
  logic [1:0]          mon4 = 2'd0, cur4, sidx4;
  logic                busy4, done4, sv4;
  logic signed [31:0]  vout4;
  logic [3:0]          pop4;
  logic [2:0]          cnt4;

  int imode = 0, ival = 0, ipos = 0;
  assign I_in = (imode == 0 || int'(cur_index) == ipos) ? ival : 32'sd0;

  izneuron_pool #(.N_NEURONS(N)) dut (
    .clk(clk), .reset(reset), .step(step), .I_in(I_in), .mon_index(mon_index),
    .cur_index(cur_index), .busy(busy), .done(done), .spike_valid(spike_valid),
    .spike_index(spike_index), .v_out(v_out), .population(population),
    .spike_count(spike_count));

  izneuron_pool #(.N_NEURONS(4)) dut4 (
    .clk(clk), .reset(reset), .step(step4), .I_in(32'sd0), .mon_index(mon4),
    .cur_index(cur4), .busy(busy4), .done(done4), .spike_valid(sv4),
    .spike_index(sidx4), .v_out(vout4), .population(pop4), .spike_count(cnt4));

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [N-1:0] pop;
    int           cnt;
  } sweep_t;

  int     mv[N], mu[N];
  int     spike_q[$];
  sweep_t sweep_q[$];
  int     exp_vout = V_INIT, mon = 0, dones_seen = 0, steps_acc = 0;
  bit     pend = 1'b0;
  sweep_t pend_e;

  function automatic int hi(input longint p, input int sh);
    return int'(p >>> sh);
  endfunction

  // Model one sweep with the current stimulus settings and queue expectations.
  task automatic predict();
    sweep_t s;
    s.pop = '0;
    s.cnt = 0;
    for (int i = 0; i < N; i++) begin
      int v, u, cur, vn, un, vv, q, dv, bv, du, vs;
      v = mv[i];
      u = mu[i];
      cur = (imode == 0 || i == ipos) ? ival : 0;
      if (v > V_PEAK) begin
        vn = C;
        un = u + D;
        spike_q.push_back(i);
        s.pop[i] = 1'b1;
        s.cnt++;
      end else begin
        vv = hi(longint'(v) * longint'(v), 10);
        q  = hi(longint'(vv) * 64'sd41, 10);
        dv = q + 5 * v + 143360 - u + cur;
        bv = hi(longint'(B) * longint'(v), 10);
        du = hi(longint'(bv - u) * longint'(A), 12);
        un = u + du;
        vs = v + dv;
        vn = (vs > V_MAX) ? V_MAX : vs;
      end
      if (i == mon) exp_vout = vn;
      mv[i] = vn;
      mu[i] = un;
    end
    sweep_q.push_back(s);
  endtask

  // Monitor: pops expected events when the DUT presents them.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        check("spike_count", longint'(spike_count), pend_e.cnt);
        n_checks++;
        if (population !== pend_e.pop) begin
          n_fail++;
          $display("FAIL population: got %h, expected %h", population, pend_e.pop);
        end
      end
      if (spike_valid === 1'b1) begin
        if (spike_q.size() == 0) check("spike_unexpected", longint'(spike_index), -1);
        else                     check("spike_index", longint'(spike_index), spike_q.pop_front());
      end
      if (done === 1'b1) begin
        dones_seen++;
        if (sweep_q.size() == 0) check("done_unexpected", longint'(done), 0);
        else begin
          pend_e = sweep_q.pop_front();
          pend   = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: time limit reached, summary not printed normally");
    $fatal(1, "watchdog");
  end

  // Reset both DUTs, reinitialise the model, check reset values and INIT length.
  task automatic do_reset();
    int nb, nb4;
    @(posedge clk); #1 reset = 1'b1; step = 1'b0; step4 = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    spike_q.delete();
    sweep_q.delete();
    pend = 1'b0;
    for (int i = 0; i < N; i++) begin
      mv[i] = V_INIT;
      mu[i] = U_INIT;
    end
    nb = 0;
    nb4 = 0;
    @(negedge clk);
    check("rst_done", longint'(done), 0);
    check("rst_spike_valid", longint'(spike_valid), 0);
    check("rst_spike_index", longint'(spike_index), 0);
    check("rst_v_out", longint'(v_out), V_INIT);
    check("rst_population_nonzero", longint'(population != '0), 0);
    check("rst_spike_count", longint'(spike_count), 0);
    check("rst_cur_index", longint'(cur_index), 0);
    for (int k = 0; k < 300; k++) begin
      if (busy)  nb++;
      if (busy4) nb4++;
      if (!busy && !busy4) break;
      @(negedge clk);
    end
    check("init_busy_cycles", nb, N);
    check("init_busy_cycles_n4", nb4, 4);
  endtask

  // One full sweep; optionally pokes step mid-sweep and in the done cycle.
  task automatic do_sweep(input bit poke);
    int n;
    bit got, busy_ok, idle_ok;
    mon_index = W'(mon);
    predict();
    steps_acc++;
    @(posedge clk); #1 step = 1'b1;
    @(posedge clk); #1 step = 1'b0;
    n = 1;
    got = 1'b0;
    busy_ok = 1'b1;
    while (n <= 4 * N) begin
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        got = 1'b1;
        break;
      end
      if (poke && n == 20) step = 1'b1;
      @(posedge clk); #1 step = 1'b0;
      n++;
    end
    check("done_seen", got, 1);
    check("sweep_latency", n, 2 * N + 1);
    check("busy_during_sweep", busy_ok, 1);
    check("v_out", longint'(v_out), exp_vout);
    if (poke) begin
      step = 1'b1;
      @(posedge clk); #1 step = 1'b0;
      idle_ok = 1'b1;
      repeat (6) begin
        @(negedge clk);
        if (busy) idle_ok = 1'b0;
      end
      check("step_in_done_ignored", idle_ok, 1);
    end
  endtask

  initial begin : stimulus
    int n;
    bit got;
    do_reset();

    // Four-neuron instance: sweep latency 2N+1 = 9.
    @(posedge clk); #1 step4 = 1'b1;
    @(posedge clk); #1 step4 = 1'b0;
    n = 1;
    got = 1'b0;
    while (n <= 40) begin
      @(negedge clk);
      if (done4) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    check("n4_done_seen", got, 1);
    check("n4_latency", n, 9);
    @(negedge clk);
    check("n4_spike_count", longint'(cnt4), 0);

    // Zero input: neuron 5 stays near rest.
    imode = 0; ival = 0; mon = 5;
    do_sweep(1'b0);
    check("rest_v5_in_band", longint'(v_out >= -69560 && v_out <= -63560), 1);

    // Uniform drive: all neurons spike together; step pokes while busy.
    ival = 10240; mon = 3;
    for (int s = 0; s < 40; s++) do_sweep(s == 3);

    // Drive only neuron 7.
    do_reset();
    imode = 1; ipos = 7; ival = 10240; mon = 7;
    for (int s = 0; s < 30; s++) do_sweep(1'b0);
    mon = 6;
    do_sweep(1'b0);

    // Saturation of v, then a spike from the clamped value.
    do_reset();
    imode = 0; ival = 32'h7FFF0000; mon = 9;
    do_sweep(1'b0);
    check("v_clamped", longint'(v_out), V_MAX);
    ival = 0;
    do_sweep(1'b0);
    check("v_after_clamp_spike", longint'(v_out), C);

    // Reset around cycle 50 of a sweep: the sweep is abandoned.
    ival = 10240; mon = 0;
    mon_index = W'(mon);
    predict();
    @(posedge clk); #1 step = 1'b1;
    @(posedge clk); #1 step = 1'b0;
    repeat (48) @(posedge clk);
    do_reset();
    repeat (20) @(negedge clk);
    check("busy_after_abort", longint'(busy), 0);
    ival = 0; mon = 5;
    do_sweep(1'b0);

    repeat (4) @(negedge clk);
    check("done_count", dones_seen, steps_acc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
